pipe_fwd_ctrl: RTL

Parametrised, registered forwarding and hazard controller for the 5-stage pipeline. It supersedes the purely combinational EX-stage forwarding logic. It tracks the destination tags of the instructions in ID/EX, EX/MEM and MEM/WB internally, and resolves forwarding one cycle early (in ID) so the EX-stage operand mux selects come straight from flops. It also detects load-use hazards, handles flush and global hold, and counts stall cycles.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/fwd_stage_reg.sv | 25 ++
 rtl/pipe_fwd_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared select encoding, stage tag type and helpers for pipe_fwd_ctrl
package pipe_pkg;

  // Widest register address a tag slot can carry; narrower REG_AW values are zero-extended.
  localparam int TAG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [TAG_AW-1:0] dest;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE = stage_tag_t'('0);

  function automatic logic is_writer(input stage_tag_t t);
    return t.valid & t.regwrite & (t.dest != '0);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// rtl/fwd_stage_reg.sv - one pipeline tag slot with hold, bubble-insert and load
module fwd_stage_reg
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_hold,
  input  logic       i_bubble,
  input  stage_tag_t i_d,
  output stage_tag_t o_q
);

  stage_tag_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= BUBBLE;
    end else if (!i_hold) begin
      r_q <= i_bubble ? BUBBLE : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_fwd_ctrl.sv
// rtl/pipe_fwd_ctrl.sv - registered forwarding / load-use hazard controller for the 5-stage pipe
// Optional feature: define FWD_WB_BYPASS_EN to drive id_wb_bypass from the MEM/WB slot.
module pipe_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_hold,
  input  logic                      ex_flush,
  input  logic                      id_valid,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic [REG_AW-1:0]         id_regdest,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  output logic [2*NUM_SRC-1:0]      ex_fwd_sel,
  output logic                      stall_id,
  output logic [NUM_SRC-1:0]        id_wb_bypass,
  output logic [CNT_W-1:0]          stall_cnt
);

  stage_tag_t           w_id_tag;
  stage_tag_t           w_idex;
  stage_tag_t           w_exmem;
  stage_tag_t           w_memwb;
  logic [NUM_SRC-1:0]   w_match_idex;
  logic [NUM_SRC-1:0]   w_match_exmem;
  logic [NUM_SRC-1:0]   w_match_memwb;
  logic [2*NUM_SRC-1:0] w_sel_next;
  logic                 w_kill;
  logic [2*NUM_SRC-1:0] r_ex_fwd_sel;
  logic [CNT_W-1:0]     r_stall_cnt;

  function automatic logic src_match(input stage_tag_t t, input logic [REG_AW-1:0] src,
                                     input logic used);
    return used & is_writer(t) & (t.dest == TAG_AW'(src));
  endfunction

  always_comb begin
    w_match_idex  = '0;
    w_match_exmem = '0;
    w_match_memwb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_match_idex[i]  = src_match(w_idex,  id_src[i*REG_AW +: REG_AW], id_src_used[i]);
      w_match_exmem[i] = src_match(w_exmem, id_src[i*REG_AW +: REG_AW], id_src_used[i]);
      w_match_memwb[i] = src_match(w_memwb, id_src[i*REG_AW +: REG_AW], id_src_used[i]);
    end
  end

  assign stall_id = id_valid & ~ex_flush & w_idex.memread & (|w_match_idex);

  // Any of these puts a bubble into ID/EX and a regfile select into EX.
  assign w_kill = ex_flush | stall_id | ~id_valid;

  always_comb begin
    w_sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_kill)
        w_sel_next[2*i +: 2] = FWD_RF;
      else if (w_match_idex[i])
        w_sel_next[2*i +: 2] = FWD_EXMEM;
      else if (w_match_exmem[i])
        w_sel_next[2*i +: 2] = FWD_MEMWB;
      else
        w_sel_next[2*i +: 2] = FWD_RF;
    end
  end

  always_comb begin
    w_id_tag          = BUBBLE;
    w_id_tag.valid    = id_valid;
    w_id_tag.regwrite = id_valid & id_regwrite;
    w_id_tag.memread  = id_valid & id_memread;
    w_id_tag.dest     = id_valid ? TAG_AW'(id_regdest) : '0;
  end

  fwd_stage_reg u_idex (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (pipe_hold),
    .i_bubble (w_kill),
    .i_d      (w_id_tag),
    .o_q      (w_idex)
  );

  fwd_stage_reg u_exmem (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (pipe_hold),
    .i_bubble (1'b0),
    .i_d      (w_idex),
    .o_q      (w_exmem)
  );

  fwd_stage_reg u_memwb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (pipe_hold),
    .i_bubble (1'b0),
    .i_d      (w_exmem),
    .o_q      (w_memwb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_fwd_sel <= '0;
      r_stall_cnt  <= '0;
    end else if (!pipe_hold) begin
      r_ex_fwd_sel <= w_sel_next;
      if (stall_id && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ex_fwd_sel = r_ex_fwd_sel;
  assign stall_cnt  = r_stall_cnt;

`ifdef FWD_WB_BYPASS_EN
  assign id_wb_bypass = w_match_memwb & {NUM_SRC{id_valid}};

  logic w_unused;
  assign w_unused = ^{w_exmem.memread, w_memwb.memread};
`else
  assign id_wb_bypass = '0;

  logic w_unused;
  assign w_unused = ^{w_exmem.memread, w_memwb.memread, w_match_memwb};
`endif

endmodule
